uart_rx_buffer_ctrl: RTL and testbench
======================================

Name: uart_rx_buffer_ctrl

Overview:
- Flow-control and buffering controller placed directly behind the uart_rx receiver in buff_uart.
- Drives the receiver's can_receive_next_word and captures each completed word into a circular FIFO.
- Presents the buffered words to the consumer on a valid/ready stream.
- Also reports fill level, a sticky overflow flag and an idle-timeout indication for packet framing.

Parameters:
- WIDTH, 8: data word width; must equal the uart_rx width.
- DEPTH, 16: FIFO entries; power of two, at least 2.
- IDLE_CYCLES, 1000: clock cycles without a new word, with data buffered, before idle asserts; at least 1.

Ports:
- clock, input, 1: system clock.
- resetn, input, 1: synchronous, active-low reset.
- rx_ready, input, 1: uart_rx ready. A level held high for several cycles per word.
- rx_data, input, WIDTH: uart_rx data; valid whenever rx_ready is high.
- rx_can_receive, output, 1: to uart_rx can_receive_next_word.
- enable, input, 1: 0 blocks new receptions. A word already in flight is still accepted.
- flush, input, 1: 1-cycle request to empty the FIFO.
- m_data, output, WIDTH: head-of-FIFO word.
- m_valid, output, 1: m_data is valid.
- m_ready, input, 1: consumer accepts.
- level, output, $clog2(DEPTH)+1: number of words held, 0..DEPTH.
- overflow, output, 1: sticky flag, set when a word is dropped.
- overflow_clear, input, 1: clears overflow.
- idle, output, 1: no word received for IDLE_CYCLES while level > 0.

Behaviour:
- Reset (resetn = 0 at a clock edge):
  - Pointers and level are 0; m_valid = 0; overflow = 0; idle = 0; rx_ready_q = 0; idle counter = 0.
  - rx_can_receive = 0 during reset.
  - FIFO contents are don't-care; m_data is don't-care while m_valid = 0.
- Capture:
  - push = rx_ready & ~rx_ready_q, with rx_ready_q a registered copy of rx_ready. Exactly one push per word regardless of how long rx_ready stays high.
  - rx_data is written at the same edge the rising edge is detected.
  - m_valid rises the cycle after that edge (latency 1 when the FIFO was empty).
- Pop:
  - pop = m_valid & m_ready.
  - m_data = mem[rd_ptr], show-ahead (no extra read latency).
- Level:
  - push only: +1. Pop only: -1. Push and pop together: unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Full: level == DEPTH.
  - A push with pop in the same cycle is accepted.
  - A push without pop drops the word, sets overflow, and leaves level and pointers unchanged.
- Empty: m_valid = 0; m_ready is ignored.
- rx_can_receive:
  - rx_can_receive = enable & (level < DEPTH), registered.
  - uart_rx has at most one word in flight and samples this signal only at start-bit detection, so !full is sufficient.
  - overflow therefore indicates only a protocol or integration error.
- Flush:
  - At the flush edge: level = 0, rd_ptr = wr_ptr = 0, m_valid = 0 next cycle.
  - A simultaneous push or pop is discarded; flush wins.
  - overflow is not affected by flush.
- overflow_clear:
  - Clears overflow.
  - If an overflow drop occurs in the same cycle, set wins.
- Idle counter:
  - Resets to 0 on push, on flush, or whenever level == 0.
  - Otherwise increments, saturating at IDLE_CYCLES.
  - idle = (counter == IDLE_CYCLES) & (level > 0), registered.
  - idle drops the cycle after a push, a flush, or the FIFO becoming empty.
- Reset mid-operation: a partial rx_ready high level after reset must not produce a push, so rx_ready_q resets to 0. Integration holds uart_rx in reset together with this block, so no stale capture occurs.
- State: FIFO control only (pointers, level, flags). No FSM beyond the idle counter.

Decomposition:
- Package buff_uart_pkg:
  - Default WIDTH and DEPTH constants.
  - Level type width function ($clog2(DEPTH)+1).
- Sub-module sync_fifo: mem, pointers and level, with push, pop and flush ports.
- The controller keeps edge detection, flow control, the overflow flag and the idle timer.

Test Plan:
- Single word: rx_data = 8'hA5 with rx_ready high for 20 cycles. Expect exactly one push; level = 1; m_valid high the cycle after the edge; m_data = A5; m_ready pops it; level = 0.
- Fill: 16 words 0x00..0x0F with m_ready = 0. Expect level = 16; rx_can_receive = 0 the cycle after the 16th push; drain returns 0x00..0x0F in order across the pointer wrap.
- Overflow: with the FIFO full, force a 17th rx_ready edge (0xEE) and m_ready = 0. Expect the word dropped, overflow = 1, level = 16. Then overflow_clear pulse: overflow = 0.
- Full with simultaneous push and pop: level = 16, m_ready = 1, rx_ready edge with 0x55 in the same cycle. Expect level stays 16 and 0x55 becomes the newest entry.
- Flush: level = 5 with a simultaneous push. Expect level = 0, m_valid = 0 next cycle, push discarded, overflow unchanged.
- Idle timeout: IDLE_CYCLES = 10; push one word and hold m_ready = 0. Expect idle = 1 from the 11th cycle after the push; a new push drops idle the next cycle. Also check idle never asserts with level = 0.

Source files
------------

// File: rtl/buff_uart_pkg.sv
// Shared defaults and helpers for the buffered UART receive path.
package buff_uart_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Fill level has to represent 0..DEPTH inclusive, hence the extra bit.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular show-ahead FIFO; flush overrides push and pop in the same cycle.
module sync_fifo
  import buff_uart_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [WIDTH-1:0]              rd_data,
  output logic [level_width(DEPTH)-1:0] level,
  output logic [level_width(DEPTH)-1:0] level_next,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full       = (level_q == LVL_W'(DEPTH));
  assign empty      = (level_q == '0);
  assign rd_data    = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign level_next = level_d;

  // Next pointers and level; a push into a full FIFO only lands if a pop frees a slot.
  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage has no reset; contents are only observed while level > 0.
  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// Flow control and buffering behind uart_rx: edge-detected capture, overflow flag, idle timer.
module uart_rx_buffer_ctrl
  import buff_uart_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int IDLE_CYCLES = 1000
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          rx_ready,
  input  logic [WIDTH-1:0]              rx_data,
  output logic                          rx_can_receive,
  input  logic                          enable,
  input  logic                          flush,
  output logic [WIDTH-1:0]              m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow,
  input  logic                          overflow_clear,
  output logic                          idle
);

  localparam int LVL_W = level_width(DEPTH);
  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);

  logic             rx_ready_q;
  logic             rx_can_q, rx_can_d;
  logic             overflow_q, overflow_d;
  logic             idle_q, idle_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             push, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] level_q, level_d;

  // uart_rx holds rx_ready high for several cycles, so only its rising edge is a word.
  assign push = rx_ready & ~rx_ready_q;
  assign pop  = m_valid & m_ready;
  assign drop = push & fifo_full & ~pop & ~flush;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .wr_data    (rx_data),
    .rd_data    (m_data),
    .level      (level_q),
    .level_next (level_d),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign m_valid        = ~fifo_empty;
  assign level          = level_q;
  assign rx_can_receive = rx_can_q;
  assign overflow       = overflow_q;
  assign idle           = idle_q;

  // Flags and idle timer; both flow control and idle look at the post-edge level so they react immediately.
  always_comb begin
    rx_can_d   = enable & (level_d < LVL_W'(DEPTH));
    overflow_d = drop | (overflow_q & ~overflow_clear);
    idle_cnt_d = idle_cnt_q;
    if (push || flush || (level_q == '0)) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + CNT_W'(1);
    end
    idle_d = (idle_cnt_d == IDLE_MAX) & (level_d != '0);
  end

  // Control registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rx_ready_q <= 1'b0;
      rx_can_q   <= 1'b0;
      overflow_q <= 1'b0;
      idle_cnt_q <= '0;
      idle_q     <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready;
      rx_can_q   <= rx_can_d;
      overflow_q <= overflow_d;
      idle_cnt_q <= idle_cnt_d;
      idle_q     <= idle_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// Directed bench for uart_rx_buffer_ctrl with hand-computed expectations.
module tb_uart_rx_buffer_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_can_receive;
  logic       enable;
  logic       flush;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] level;
  logic       overflow;
  logic       overflow_clear;
  logic       idle;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  uart_rx_buffer_ctrl #(
    .WIDTH       (8),
    .DEPTH       (16),
    .IDLE_CYCLES (10)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .rx_ready       (rx_ready),
    .rx_data        (rx_data),
    .rx_can_receive (rx_can_receive),
    .enable         (enable),
    .flush          (flush),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .level          (level),
    .overflow       (overflow),
    .overflow_clear (overflow_clear),
    .idle           (idle)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One word: rx_ready high for a cycle (the push edge), then low for a cycle.
  task automatic send_word(input logic [7:0] d);
    rx_data  = d;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  initial begin
    resetn = 1'b0; rx_ready = 1'b0; rx_data = '0; enable = 1'b0;
    flush = 1'b0; m_ready = 1'b0; overflow_clear = 1'b0;
    repeat (3) tick();
    check("rst_level",    32'(level), 32'd0);
    check("rst_valid",    32'(m_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_idle",     32'(idle), 32'd0);
    check("rst_can",      32'(rx_can_receive), 32'd0);
    resetn = 1'b1; enable = 1'b1;
    tick();
    check("can_after_rst", 32'(rx_can_receive), 32'd1);

    // Single word held high for 20 cycles.
    rx_data = 8'hA5; rx_ready = 1'b1;
    tick();
    check("single_valid", 32'(m_valid), 32'd1);
    check("single_level", 32'(level), 32'd1);
    check("single_data",  32'(m_data), 32'hA5);
    repeat (19) tick();
    check("single_one_push", 32'(level), 32'd1);
    rx_ready = 1'b0;
    tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("single_pop_level", 32'(level), 32'd0);
    check("single_pop_valid", 32'(m_valid), 32'd0);

    // Fill to 16 without popping.
    for (int i = 0; i < 16; i++) send_word(8'(i));
    check("fill_level", 32'(level), 32'd16);
    check("fill_can",   32'(rx_can_receive), 32'd0);

    // 17th word while full and no pop: dropped.
    send_word(8'hEE);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_head",  32'(m_data), 32'h00);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop.
    m_ready = 1'b1; rx_data = 8'h55; rx_ready = 1'b1;
    tick();
    m_ready = 1'b0; rx_ready = 1'b0;
    check("pp_level",    32'(level), 32'd16);
    check("pp_head",     32'(m_data), 32'h01);
    check("pp_overflow", 32'(overflow), 32'd0);
    tick();

    // Drain across the pointer wrap: 01..0F then 55.
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_data", 32'(m_data), (i < 15) ? 32'(i + 1) : 32'h55);
      tick();
    end
    m_ready = 1'b0;
    check("drain_level", 32'(level), 32'd0);
    check("drain_valid", 32'(m_valid), 32'd0);

    // Flush with a simultaneous push.
    for (int i = 0; i < 5; i++) send_word(8'(8'h10 + i));
    check("flush_pre_level", 32'(level), 32'd5);
    rx_data = 8'h77; rx_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_valid", 32'(m_valid), 32'd0);
    check("flush_ovf",   32'(overflow), 32'd0);
    rx_ready = 1'b0;
    repeat (2) tick();
    check("flush_push_gone", 32'(level), 32'd0);

    // No idle while empty.
    for (int i = 0; i < 15; i++) begin
      tick();
      check("idle_empty", 32'(idle), 32'd0);
    end

    // Idle timeout with IDLE_CYCLES = 10.
    rx_data = 8'h3C; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("idle_push_level", 32'(level), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("idle_early", 32'(idle), 32'd0);
    end
    tick();
    check("idle_asserted", 32'(idle), 32'd1);
    tick();
    check("idle_held", 32'(idle), 32'd1);
    rx_data = 8'h4D; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("idle_drop", 32'(idle), 32'd0);
    check("idle_level2", 32'(level), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
